// File: rtl/aim_pkg.sv
`default_nettype none
// aim_pkg: shared width, neuron-model defaults, FSM encoding and saturating add
// for the AIM step scheduler.  Rev 1.0
package aim_pkg;

  localparam int DW = 16;

  localparam logic signed [DW-1:0] V_TH_DEF    = 16'sd30;
  localparam logic signed [DW-1:0] V_RESET_DEF = -16'sd65;
  localparam logic signed [DW-1:0] U_INIT_DEF  = -16'sd13;
  localparam logic signed [DW-1:0] U_INC_DEF   = 16'sd8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_WB    = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Operands arrive sign-extended; the result is clamped to a signed w-bit range.
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int                 w);
    logic signed [63:0] sum;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sum = a + b;
    hi  = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo  = -(64'sd1 <<< (w - 1));
    if (sum > hi) return hi;
    if (sum < lo) return lo;
    return sum;
  endfunction

endpackage
`default_nettype wire

// File: rtl/aim_state_mem.sv
`default_nettype none
// aim_state_mem: per-neuron v/u/i storage with a writeback port, a current-write
// port and combinational reads at the scheduler index and the probe index.  Rev 1.0
module aim_state_mem #(
  parameter int                    N_NEURONS = 8,
  parameter int                    DW        = aim_pkg::DW,
  parameter logic signed [DW-1:0]  V_RESET   = aim_pkg::V_RESET_DEF,
  parameter logic signed [DW-1:0]  U_INIT    = aim_pkg::U_INIT_DEF,
  localparam int                   AW        = $clog2(N_NEURONS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wb_we,
  input  logic [AW-1:0]        wb_addr,
  input  logic signed [DW-1:0] wb_v,
  input  logic signed [DW-1:0] wb_u,
  input  logic                 cur_we,
  input  logic [AW-1:0]        cur_addr,
  input  logic signed [DW-1:0] cur_data,
  input  logic [AW-1:0]        rd_addr,
  output logic signed [DW-1:0] rd_v,
  output logic signed [DW-1:0] rd_u,
  output logic signed [DW-1:0] rd_i,
  input  logic [AW-1:0]        probe_addr,
  output logic signed [DW-1:0] probe_v
);

  logic signed [DW-1:0] r_v_mem [N_NEURONS];
  logic signed [DW-1:0] r_u_mem [N_NEURONS];
  logic signed [DW-1:0] r_i_mem [N_NEURONS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_NEURONS; k++) begin
        r_v_mem[k] <= V_RESET;
        r_u_mem[k] <= U_INIT;
      end
    end else if (wb_we) begin
      r_v_mem[wb_addr] <= wb_v;
      r_u_mem[wb_addr] <= wb_u;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_NEURONS; k++) begin
        r_i_mem[k] <= '0;
      end
    end else if (cur_we) begin
      r_i_mem[cur_addr] <= cur_data;
    end
  end

  assign rd_v    = r_v_mem[rd_addr];
  assign rd_u    = r_u_mem[rd_addr];
  assign rd_i    = r_i_mem[rd_addr];
  assign probe_v = r_v_mem[probe_addr];

endmodule
`default_nettype wire

// File: rtl/aim_step_scheduler.sv
`default_nettype none
// aim_step_scheduler: time-multiplexes one AIM neuron-update core over N_NEURONS
// virtual neurons, applying spike/reset rules on writeback.  Rev 1.0
module aim_step_scheduler #(
  parameter int                    N_NEURONS = 8,
  parameter int                    DW        = aim_pkg::DW,
  parameter logic signed [DW-1:0]  V_TH      = aim_pkg::V_TH_DEF,
  parameter logic signed [DW-1:0]  V_RESET   = aim_pkg::V_RESET_DEF,
  parameter logic signed [DW-1:0]  U_INIT    = aim_pkg::U_INIT_DEF,
  parameter logic signed [DW-1:0]  U_INC     = aim_pkg::U_INC_DEF,
  localparam int                   AW        = $clog2(N_NEURONS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 cur_we,
  input  logic [AW-1:0]        cur_addr,
  input  logic signed [DW-1:0] cur_data,
  input  logic [AW-1:0]        probe_sel,
  output logic                 core_req_valid,
  input  logic                 core_req_ready,
  output logic [AW-1:0]        core_req_id,
  output logic signed [DW-1:0] core_req_v,
  output logic signed [DW-1:0] core_req_u,
  output logic signed [DW-1:0] core_req_i,
  input  logic                 core_rsp_valid,
  input  logic signed [DW-1:0] core_rsp_v,
  input  logic signed [DW-1:0] core_rsp_u,
  output logic                 busy,
  output logic                 step_done,
  output logic                 spike_valid,
  output logic [AW-1:0]        spike_id,
  output logic                 overrun,
  output logic signed [DW-1:0] out_neuron
);

  import aim_pkg::*;

  localparam logic [AW-1:0] c_last_idx = AW'(N_NEURONS - 1);

  state_t               r_state;
  state_t               w_state_nx;
  logic [AW-1:0]        r_idx;
  logic signed [DW-1:0] r_rsp_v;
  logic signed [DW-1:0] r_rsp_u;
  logic signed [DW-1:0] r_req_v;
  logic signed [DW-1:0] r_req_u;
  logic signed [DW-1:0] r_req_i;
  logic                 r_overrun;
  logic signed [DW-1:0] r_out_neuron;

  logic [AW-1:0]        w_rd_addr;
  logic signed [DW-1:0] w_rd_v;
  logic signed [DW-1:0] w_rd_u;
  logic signed [DW-1:0] w_rd_i;
  logic signed [DW-1:0] w_probe_v;
  logic                 w_load_req;
  logic                 w_wb_we;
  logic                 w_fire;
  logic signed [DW-1:0] w_wb_v;
  logic signed [DW-1:0] w_wb_u;
  logic signed [DW-1:0] w_u_bumped;

  aim_state_mem #(
    .N_NEURONS (N_NEURONS),
    .DW        (DW),
    .V_RESET   (V_RESET),
    .U_INIT    (U_INIT)
  ) u_state_mem (
    .clk        (clk),
    .rst        (rst),
    .wb_we      (w_wb_we),
    .wb_addr    (r_idx),
    .wb_v       (w_wb_v),
    .wb_u       (w_wb_u),
    .cur_we     (cur_we),
    .cur_addr   (cur_addr),
    .cur_data   (cur_data),
    .rd_addr    (w_rd_addr),
    .rd_v       (w_rd_v),
    .rd_u       (w_rd_u),
    .rd_i       (w_rd_i),
    .probe_addr (probe_sel),
    .probe_v    (w_probe_v)
  );

  // The request register is loaded on ISSUE entry, so memory is read at the
  // index about to be issued: 0 from IDLE, idx+1 from WB.
  assign w_rd_addr  = (r_state == S_WB) ? r_idx + AW'(1) : '0;
  assign w_u_bumped = DW'(sat_add(64'(r_rsp_u), 64'(U_INC), DW));
  assign w_fire     = (r_state == S_WB) && (r_rsp_v >= V_TH);
  assign w_wb_v     = w_fire ? V_RESET : r_rsp_v;
  assign w_wb_u     = w_fire ? w_u_bumped : r_rsp_u;

  always_comb begin
    w_state_nx = r_state;
    w_load_req = 1'b0;
    w_wb_we    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nx = S_ISSUE;
          w_load_req = 1'b1;
        end
      end
      S_ISSUE: begin
        if (core_req_ready) w_state_nx = S_WAIT;
      end
      S_WAIT: begin
        if (core_rsp_valid) w_state_nx = S_WB;
      end
      S_WB: begin
        w_wb_we = 1'b1;
        if (r_idx == c_last_idx) begin
          w_state_nx = S_DONE;
        end else begin
          w_state_nx = S_ISSUE;
          w_load_req = 1'b1;
        end
      end
      S_DONE: w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_rsp_v      <= '0;
      r_rsp_u      <= '0;
      r_req_v      <= '0;
      r_req_u      <= '0;
      r_req_i      <= '0;
      r_overrun    <= 1'b0;
      r_out_neuron <= V_RESET;
    end else begin
      r_state      <= w_state_nx;
      r_overrun    <= start && (r_state != S_IDLE);
      r_out_neuron <= w_probe_v;
      if (w_load_req) begin
        r_req_v <= w_rd_v;
        r_req_u <= w_rd_u;
        r_req_i <= w_rd_i;
      end
      if ((r_state == S_WAIT) && core_rsp_valid) begin
        r_rsp_v <= core_rsp_v;
        r_rsp_u <= core_rsp_u;
      end
      if ((r_state == S_IDLE) || (r_state == S_DONE)) begin
        r_idx <= '0;
      end else if ((r_state == S_WB) && (r_idx != c_last_idx)) begin
        r_idx <= r_idx + AW'(1);
      end
    end
  end

  assign core_req_valid = (r_state == S_ISSUE);
  assign core_req_id    = r_idx;
  assign core_req_v     = r_req_v;
  assign core_req_u     = r_req_u;
  assign core_req_i     = r_req_i;
  assign busy           = (r_state == S_ISSUE) || (r_state == S_WAIT) || (r_state == S_WB);
  assign step_done      = (r_state == S_DONE);
  assign spike_valid    = w_fire;
  assign spike_id       = w_fire ? r_idx : '0;
  assign overrun        = r_overrun;
  assign out_neuron     = r_out_neuron;

endmodule
`default_nettype wire
